// File: rtl/alu.sv
// RV32I execute-stage ALU: combinational result/branch plus a registered copy.
// Define ALU_ZERO_FLAG_EN to add the zero / zero_q outputs.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  op_code,
    output logic [31:0] result,
    output logic        branch,
`ifdef ALU_ZERO_FLAG_EN
    output logic        zero,
    output logic        zero_q,
`endif
    output logic [31:0] result_q,
    output logic        branch_q
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRA  = 4'h6,
        OP_SRL  = 4'h7,
        OP_SLT  = 4'h8,
        OP_SLTU = 4'h9,
        OP_BEQ  = 4'hA,
        OP_BNE  = 4'hB,
        OP_BGE  = 4'hC,
        OP_BGEU = 4'hD,
        OP_BLT  = 4'hE,
        OP_BLTU = 4'hF
    } op_e;

    logic [4:0] w_shamt;
    logic       w_eq;
    logic       w_lt_s;
    logic       w_lt_u;

    // Only the low five bits of operand2 select the shift distance.
    assign w_shamt = operand2[4:0];
    assign w_eq    = (operand1 == operand2);
    assign w_lt_s  = ($signed(operand1) < $signed(operand2));
    assign w_lt_u  = (operand1 < operand2);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        result = '0;
        branch = 1'b0;
        case (op_e'(op_code))
            OP_ADD:  result = operand1 + operand2;
            OP_SUB:  result = operand1 - operand2;
            OP_AND:  result = operand1 & operand2;
            OP_OR:   result = operand1 | operand2;
            OP_XOR:  result = operand1 ^ operand2;
            OP_SLL:  result = operand1 << w_shamt;
            OP_SRA:  result = 32'($signed(operand1) >>> w_shamt);
            OP_SRL:  result = operand1 >> w_shamt;
            OP_SLT:  result = {31'b0, w_lt_s};
            OP_SLTU: result = {31'b0, w_lt_u};
            OP_BEQ:  branch = w_eq;
            OP_BNE:  branch = ~w_eq;
            OP_BGE:  branch = ~w_lt_s;
            OP_BGEU: branch = ~w_lt_u;
            OP_BLT:  branch = w_lt_s;
            OP_BLTU: branch = w_lt_u;
            default: begin
                result = '0;
                branch = 1'b0;
            end
        endcase
    end

`ifdef ALU_ZERO_FLAG_EN
    assign zero = (result == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            result_q <= '0;
            branch_q <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else begin
            result_q <= result;
            branch_q <= branch;
`ifdef ALU_ZERO_FLAG_EN
            zero_q   <= zero;
`endif
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected responses, monitor checks
// combinational and registered outputs one edge after each vector is applied.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  op_code;
    logic [31:0] result;
    logic        branch;
    logic [31:0] result_q;
    logic        branch_q;
`ifdef ALU_ZERO_FLAG_EN
    logic        zero;
    logic        zero_q;
`endif

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .operand1 (operand1),
        .operand2 (operand2),
        .op_code  (op_code),
        .result   (result),
        .branch   (branch),
`ifdef ALU_ZERO_FLAG_EN
        .zero     (zero),
        .zero_q   (zero_q),
`endif
        .result_q (result_q),
        .branch_q (branch_q)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        br;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic br);
        exp_t e;
        @(negedge clk);
        op_code  = op;
        operand1 = a;
        operand2 = b;
        e.name = name;
        e.res  = res;
        e.br   = br;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() > 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        #2;
    endtask

    // Monitor: one expected entry per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0 && !rst) begin
                e = sb_q.pop_front();
                check({e.name, " result"},   result,   e.res);
                check({e.name, " branch"},   {31'b0, branch},   {31'b0, e.br});
                check({e.name, " result_q"}, result_q, e.res);
                check({e.name, " branch_q"}, {31'b0, branch_q}, {31'b0, e.br});
`ifdef ALU_ZERO_FLAG_EN
                check({e.name, " zero"},   {31'b0, zero},   {31'b0, (e.res == 32'd0)});
                check({e.name, " zero_q"}, {31'b0, zero_q}, {31'b0, (e.res == 32'd0)});
`endif
            end
        end
    end

    initial begin
        rst      = 1'b1;
        op_code  = 4'h0;
        operand1 = 32'd20;
        operand2 = 32'd21;
        repeat (2) @(posedge clk);
        #1;
        check("reset result_q", result_q, 32'd0);
        check("reset branch_q", {31'b0, branch_q}, 32'd0);
        check("reset comb result", result, 32'd41);
`ifdef ALU_ZERO_FLAG_EN
        check("reset zero_q", {31'b0, zero_q}, 32'd1);
`endif
        @(negedge clk);
        rst = 1'b0;

        run("add",       4'h0, 32'd20,        32'd21,        32'd41,        1'b0);
        run("sub",       4'h1, 32'd20,        32'd21,        32'hFFFFFFFF,  1'b0);
        run("and",       4'h2, 32'hFF,        32'hF0,        32'hF0,        1'b0);
        run("or",        4'h3, 32'hF0,        32'h0F,        32'hFF,        1'b0);
        run("xor",       4'h4, 32'hF0,        32'hFF,        32'h0F,        1'b0);
        run("sll",       4'h5, 32'h0F,        32'd4,         32'hF0,        1'b0);
        run("sra",       4'h6, 32'hF0000000,  32'd4,         32'hFF000000,  1'b0);
        run("srl",       4'h7, 32'hF0000000,  32'd4,         32'h0F000000,  1'b0);
        run("sll_hi",    4'h5, 32'h0F,        32'h24,        32'hF0,        1'b0);
        run("sll_0",     4'h5, 32'h12345678,  32'hFFFFFFE0,  32'h12345678,  1'b0);
        run("sra_31",    4'h6, 32'h80000000,  32'd31,        32'hFFFFFFFF,  1'b0);
        run("srl_31",    4'h7, 32'h80000000,  32'd31,        32'h00000001,  1'b0);
        run("slt_neg",   4'h8, 32'hFFFFFFFE,  32'd2,         32'd1,         1'b0);
        run("slt_pos",   4'h8, 32'd2,         32'd1,         32'd0,         1'b0);
        run("sltu_lt",   4'h9, 32'd1,         32'd2,         32'd1,         1'b0);
        run("sltu_big",  4'h9, 32'hFFFFFFFE,  32'd1,         32'd0,         1'b0);
        run("beq_t",     4'hA, 32'd2,         32'd2,         32'd0,         1'b1);
        run("beq_f",     4'hA, 32'd1,         32'd2,         32'd0,         1'b0);
        run("bne_t",     4'hB, 32'd1,         32'd2,         32'd0,         1'b1);
        run("bne_f",     4'hB, 32'd1,         32'd1,         32'd0,         1'b0);
        run("bge_neg",   4'hC, 32'd2,         32'hFFFFFFFE,  32'd0,         1'b1);
        run("bge_eq",    4'hC, 32'd2,         32'd2,         32'd0,         1'b1);
        run("bge_f",     4'hC, 32'd1,         32'd2,         32'd0,         1'b0);
        run("bgeu_f",    4'hD, 32'd2,         32'hFFFFFFFD,  32'd0,         1'b0);
        run("bgeu_eq",   4'hD, 32'hFFFFFFFE,  32'hFFFFFFFE,  32'd0,         1'b1);
        run("bgeu_t",    4'hD, 32'd4,         32'd2,         32'd0,         1'b1);
        run("blt_neg",   4'hE, 32'hFFFFFFFE,  32'd2,         32'd0,         1'b1);
        run("blt_eq",    4'hE, 32'd2,         32'd2,         32'd0,         1'b0);
        run("blt_f",     4'hE, 32'd4,         32'd2,         32'd0,         1'b0);
        run("bltu_big",  4'hF, 32'hFFFFFFFC,  32'd2,         32'd0,         1'b0);
        run("bltu_t",    4'hF, 32'd2,         32'd4,         32'd0,         1'b1);
        run("bltu_eq",   4'hF, 32'd2,         32'd2,         32'd0,         1'b0);
        run("sub_zero",  4'h1, 32'd5,         32'd5,         32'd0,         1'b0);
        run("add_nz",    4'h0, 32'd1,         32'd0,         32'd1,         1'b0);
        run("beq_last",  4'hA, 32'd7,         32'd7,         32'd0,         1'b1);
        run("add_last",  4'h0, 32'd20,        32'd21,        32'd41,        1'b0);
        drain();

        // Asynchronous reset between edges: registers clear at once, comb path untouched.
        rst = 1'b1;
        #1;
        check("async rst result_q", result_q, 32'd0);
        check("async rst branch_q", {31'b0, branch_q}, 32'd0);
        check("async rst result", result, 32'd41);
`ifdef ALU_ZERO_FLAG_EN
        check("async rst zero_q", {31'b0, zero_q}, 32'd1);
`endif
        @(posedge clk);
        #1;
        check("held rst result_q", result_q, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational 32-bit integer ALU for the RV32I execute stage. It provides arithmetic, logic, shift and set-less-than results, and evaluates the branch condition for conditional branches. Both outputs are available in the same cycle as the operands. A registered copy of both outputs, clocked and asynchronously reset, feeds downstream pipeline stages.

## Interface
- Parameters: none; datapath width fixed at 32.
- clk  in  1  rising-edge clock for registered outputs only.
- rst  in  1  reset, asynchronous and active-high.
- operand1  in  32  first operand (rs1 / PC).
- operand2  in  32  second operand (rs2 / immediate / shift amount).
- op_code  in  4  operation select.
- result  out  32  combinational result.
- branch  out  1  combinational branch-taken flag.
- result_q  out  32  result registered on clk.
- branch_q  out  1  branch registered on clk.
- zero, zero_q  out  1  present only with ALU_ZERO_FLAG_EN (see Configuration).

## Operation
- op_code decode for result (branch = 0 for codes 0x0–0x9):
  - 0x0 add: op1+op2, mod 2^32.
  - 0x1 sub: op1−op2, mod 2^32.
  - 0x2 and, 0x3 or, 0x4 xor: bitwise.
  - 0x5 sll: op1 << op2[4:0].
  - 0x6 sra: arithmetic right shift by op2[4:0], sign-filled.
  - 0x7 srl: logical right shift by op2[4:0], zero-filled.
  - 0x8 slt: 1 if signed(op1) < signed(op2), else 0.
  - 0x9 sltu: 1 if unsigned(op1) < unsigned(op2), else 0.
- Branch codes 0xA–0xF: result = 0; branch as follows.
  - 0xA beq: op1 == op2.
  - 0xB bne: op1 != op2.
  - 0xC bge: signed op1 ≥ op2.
  - 0xD bgeu: unsigned op1 ≥ op2.
  - 0xE blt: signed op1 < op2.
  - 0xF bltu: unsigned op1 < op2.
- Shift rules:
  - op2[31:5] ignored.
  - Shift by 0 returns op1 unchanged.
- Arithmetic rules:
  - No overflow or carry outputs.
  - slt/sltu results are zero-extended to 32 bits.
- All 16 codes are defined; no X is ever produced from known inputs.

## Timing
- result/branch: purely combinational.
  - Zero-cycle latency.
  - Settle within one clock period of any input change.
- result_q/branch_q:
  - Capture result/branch on every rising clk edge.
  - Latency 1 cycle.
  - No enable and no handshake.
- Reset:
  - rst high forces result_q = 0 and branch_q = 0 immediately, without waiting for clk.
  - Values held while rst is high.
  - First capture occurs on the first rising edge after rst deasserts.
  - Reset does not affect the combinational outputs.

## Configuration
- ALU_ZERO_FLAG_EN defined:
  - Adds output zero = (result == 0).
  - Adds zero_q, registered like result_q, reset value 1.
- ALU_ZERO_FLAG_EN undefined: ports zero and zero_q do not exist; all other behaviour is identical.

## Test plan
- Arithmetic and logic:
  - add 20,21 -> 41.
  - sub 20,21 -> 0xFFFFFFFF.
  - and 0xFF,0xF0 -> 0xF0.
  - or 0xF0,0x0F -> 0xFF.
  - xor 0xF0,0xFF -> 0x0F.
  - All with branch = 0.
- Shifts:
  - sll 0x0F by 4 -> 0xF0.
  - sra 0xF0000000 by 4 -> 0xFF000000.
  - srl 0xF0000000 by 4 -> 0x0F000000.
  - sll with op2 = 0x24 -> shift by 4.
- Compare:
  - slt −2,2 -> 1.
  - slt 2,1 -> 0.
  - sltu 1,2 -> 1.
  - sltu 0xFFFFFFFE,1 -> 0.
- Branches (result = 0 for every case):
  - beq 2,2 -> 1; beq 1,2 -> 0.
  - bne 1,2 -> 1; bne 1,1 -> 0.
  - bge 2,−2 -> 1; bge 2,2 -> 1; bge 1,2 -> 0.
  - bgeu 2,0xFFFFFFFD -> 0; bgeu 0xFFFFFFFE,0xFFFFFFFE -> 1; bgeu 4,2 -> 1.
  - blt −2,2 -> 1; blt 2,2 -> 0; blt 4,2 -> 0.
  - bltu 0xFFFFFFFC,2 -> 0; bltu 2,4 -> 1; bltu 2,2 -> 0.
- Registered path:
  - Apply add 20,21 with rst low -> result_q = 41 one edge later.
  - Assert rst between edges -> result_q = 0 and branch_q = 0 immediately, while result stays 41.
- Config: with ALU_ZERO_FLAG_EN defined:
  - sub 5,5 -> zero = 1.
  - add 1,0 -> zero = 0.
  - During rst -> zero_q = 1.
